hyperram_ca_gen: RTL and testbench

Parametrised HyperRAM command/address generator that turns a byte-addressed transfer request into one or more page-bounded 48-bit CA words. It sits between the host request port and the HyperBus PHY sequencer. It splits transfers at page boundaries and also emits page, row and buffer indices for the data buffer. It is a registered valid/ready stage with a split state machine.

---
 rtl/hyperram_pkg.sv | 24 ++
 rtl/hyperram_ca_gen_if.sv | 48 ++++
 rtl/hyperram_ca_pack.sv | 26 ++
 rtl/hyperram_ca_gen.sv | 163 ++++++++++++++++
 tb/tb_hyperram_ca_gen.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/hyperram_pkg.sv
// Shared HyperRAM CA definitions: bit positions, CA word layout and generator FSM states.
package hyperram_pkg;

  localparam int CA_W  = 48;
  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  typedef struct packed {
    logic        rw;
    logic        as;
    logic        bt;
    logic [28:0] row_hi;
    logic [12:0] rsvd;
    logic [2:0]  col;
  } ca_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_ERR
  } ca_state_e;

endpackage

// File: rtl/hyperram_ca_gen_if.sv
// Request and CA port bundle of hyperram_ca_gen; req_wrap exists only with HYPERRAM_CA_GEN_WRAP_EN.
interface hyperram_ca_gen_if #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 10,
  parameter int ROW_W     = 14,
  parameter int PAGE_ID_W = 5,
  parameter int BUF_W     = 5
);
  import hyperram_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic [LEN_W-1:0]     req_len;
  logic                 req_read;
  logic                 req_reg;
`ifdef HYPERRAM_CA_GEN_WRAP_EN
  logic                 req_wrap;
`endif
  logic                 ca_valid;
  logic                 ca_ready;
  logic [CA_W-1:0]      ca_word;
  logic [LEN_W-1:0]     ca_len;
  logic                 ca_last;
  logic [PAGE_ID_W-1:0] ca_page_id;
  logic [ROW_W-1:0]     ca_row_id;
  logic [BUF_W-1:0]     ca_buf_addr;
  logic                 err;

  modport master (
`ifdef HYPERRAM_CA_GEN_WRAP_EN
    output req_wrap,
`endif
    output req_valid, req_addr, req_len, req_read, req_reg, ca_ready,
    input  req_ready, ca_valid, ca_word, ca_len, ca_last,
    input  ca_page_id, ca_row_id, ca_buf_addr, err
  );

  modport slave (
`ifdef HYPERRAM_CA_GEN_WRAP_EN
    input  req_wrap,
`endif
    input  req_valid, req_addr, req_len, req_read, req_reg, ca_ready,
    output req_ready, ca_valid, ca_word, ca_len, ca_last,
    output ca_page_id, ca_row_id, ca_buf_addr, err
  );

endinterface

// File: rtl/hyperram_ca_pack.sv
// Combinational packer from burst attributes and word address to the 48-bit HyperBus CA word.
module hyperram_ca_pack
  import hyperram_pkg::*;
(
  input  logic            rd,
  input  logic            rg,
  input  logic            lin,
  input  logic [31:0]     word_addr,
  output logic [CA_W-1:0] ca
);

  ca_fields_t f;

  always_comb begin
    f        = '0;
    f.rw     = rd;
    f.as     = rg;
    f.bt     = lin;
    f.row_hi = word_addr[31:3];
    f.rsvd   = '0;
    f.col    = word_addr[2:0];
  end

  assign ca = f;

endmodule

// File: rtl/hyperram_ca_gen.sv
// HyperRAM CA generator: splits byte-addressed requests into page-bounded CA bursts.
// Optional wrapped bursts are enabled with HYPERRAM_CA_GEN_WRAP_EN.
module hyperram_ca_gen
  import hyperram_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 10,
  parameter int PAGE_BYTES = 32,
  parameter int ROW_LSB    = 10,
  parameter int ROW_W      = 14,
  parameter int PAGE_ID_W  = 5
) (
  input logic               clk,
  input logic               rst_n,
  hyperram_ca_gen_if.slave  bus
);

  localparam int PB_LOG = $clog2(PAGE_BYTES);
  localparam int CW     = (LEN_W > PB_LOG + 1) ? LEN_W : PB_LOG + 1;

  ca_state_e state, state_nx;

  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     rem_q, chunk_q;
  logic                 rd_q, rg_q, lin_q, single_q;
  logic [CA_W-1:0]      ca_word_q;
  logic [LEN_W-1:0]     ca_len_q;
  logic                 ca_last_q;
  logic [PAGE_ID_W-1:0] page_id_q;
  logic [ROW_W-1:0]     row_id_q;
  logic [PB_LOG-1:0]    buf_addr_q;

  logic                 req_wrap, accept, bad_req, hs, ld;
  logic [ADDR_W-1:0]    nxt_addr, src_addr, pg_full;
  logic [LEN_W-1:0]     nxt_rem, src_rem, chunk, ld_len;
  logic                 src_rd, src_rg, src_lin, src_single;
  logic [PB_LOG:0]      room_b;
  logic [CW-1:0]        room_w, rem_w;
  logic [CA_W-1:0]      ca_pack;
  logic [31:0]          word_addr;
  logic                 unused_bits;

`ifdef HYPERRAM_CA_GEN_WRAP_EN
  assign req_wrap = bus.req_wrap;
`else
  assign req_wrap = 1'b0;
`endif

  assign accept  = bus.req_valid && (state == ST_IDLE);
  assign bad_req = (bus.req_len == '0) ||
                   (req_wrap && (bus.req_len != LEN_W'(PAGE_BYTES / 2)));
  assign hs      = (state == ST_EMIT) && bus.ca_ready;
  assign nxt_addr = addr_q + ADDR_W'({chunk_q, 1'b0});
  assign nxt_rem  = rem_q - chunk_q;

  // Load source: the new request while idle, otherwise the continuation of the current one.
  always_comb begin
    src_addr = nxt_addr;
    src_rem  = nxt_rem;
    src_rd   = rd_q;
    src_rg   = rg_q;
    src_lin  = lin_q;
    if (state == ST_IDLE) begin
      src_addr = {bus.req_addr[ADDR_W-1:1], 1'b0};
      src_rem  = bus.req_len;
      src_rd   = bus.req_read;
      src_rg   = bus.req_reg;
      src_lin  = ~req_wrap;
    end
  end

  assign src_single = src_rg | ~src_lin;
  assign room_b     = (PB_LOG + 1)'(PAGE_BYTES) - {1'b0, src_addr[PB_LOG-1:0]};
  assign room_w     = CW'(room_b >> 1);
  assign rem_w      = CW'(src_rem);
  assign chunk      = (rem_w < room_w) ? src_rem : LEN_W'(room_w);
  assign ld_len     = src_rg ? LEN_W'(1) : (src_lin ? chunk : src_rem);
  assign word_addr  = 32'(src_addr[ADDR_W-1:1]);
  assign pg_full    = src_addr >> PB_LOG;
  assign unused_bits = ^{bus.req_addr[0], pg_full[ADDR_W-1:PAGE_ID_W]};

  hyperram_ca_pack u_pack (
    .rd        (src_rd),
    .rg        (src_rg),
    .lin       (src_lin),
    .word_addr (word_addr),
    .ca        (ca_pack)
  );

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bad_req) begin
            state_nx = ST_ERR;
          end else begin
            state_nx = ST_EMIT;
            ld       = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (hs) begin
          if (single_q || (nxt_rem == '0)) state_nx = ST_IDLE;
          else                             ld       = 1'b1;
        end
      end
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Burst registers: loaded on acceptance and on every non-final CA handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      rd_q       <= 1'b0;
      rg_q       <= 1'b0;
      lin_q      <= 1'b0;
      single_q   <= 1'b0;
      ca_word_q  <= '0;
      ca_len_q   <= '0;
      ca_last_q  <= 1'b0;
      page_id_q  <= '0;
      row_id_q   <= '0;
      buf_addr_q <= '0;
    end else if (ld) begin
      addr_q     <= src_addr;
      rem_q      <= src_rem;
      chunk_q    <= chunk;
      rd_q       <= src_rd;
      rg_q       <= src_rg;
      lin_q      <= src_lin;
      single_q   <= src_single;
      ca_word_q  <= ca_pack;
      ca_len_q   <= ld_len;
      ca_last_q  <= src_single | (chunk == src_rem);
      page_id_q  <= pg_full[PAGE_ID_W-1:0];
      row_id_q   <= src_addr[ROW_LSB+ROW_W-1:ROW_LSB];
      buf_addr_q <= src_addr[PB_LOG-1:0];
    end
  end

  assign bus.req_ready   = (state == ST_IDLE);
  assign bus.ca_valid    = (state == ST_EMIT);
  assign bus.err         = (state == ST_ERR);
  assign bus.ca_word     = ca_word_q;
  assign bus.ca_len      = ca_len_q;
  assign bus.ca_last     = ca_last_q;
  assign bus.ca_page_id  = page_id_q;
  assign bus.ca_row_id   = row_id_q;
  assign bus.ca_buf_addr = buf_addr_q;

endmodule

// File: tb/tb_hyperram_ca_gen.sv
// Directed bench for hyperram_ca_gen with default parameters (PAGE_BYTES = 32).
module tb_hyperram_ca_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  hyperram_ca_gen_if #(.ADDR_W(32), .LEN_W(10), .ROW_W(14), .PAGE_ID_W(5), .BUF_W(5)) bus_if ();

  hyperram_ca_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] addr, input logic [9:0] len,
                      input logic rd, input logic rg, input logic wr);
    chk("req_ready_before_send", 64'(bus_if.req_ready), 64'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = addr;
    bus_if.req_len   = len;
    bus_if.req_read  = rd;
    bus_if.req_reg   = rg;
`ifdef HYPERRAM_CA_GEN_WRAP_EN
    bus_if.req_wrap  = wr;
`else
    if (wr) $display("note: wrap request issued in a linear-only build");
`endif
    tick();
    bus_if.req_valid = 1'b0;
`ifdef HYPERRAM_CA_GEN_WRAP_EN
    bus_if.req_wrap  = 1'b0;
`endif
  endtask

  task automatic expect_ca(input string tag, input logic [47:0] word, input logic [9:0] len,
                           input logic last, input logic [4:0] pid, input logic [13:0] row,
                           input logic [4:0] buf_a);
    chk({tag, "_valid"}, 64'(bus_if.ca_valid), 64'd1);
    chk({tag, "_word"},  64'(bus_if.ca_word), 64'(word));
    chk({tag, "_len"},   64'(bus_if.ca_len), 64'(len));
    chk({tag, "_last"},  64'(bus_if.ca_last), 64'(last));
    chk({tag, "_page"},  64'(bus_if.ca_page_id), 64'(pid));
    chk({tag, "_row"},   64'(bus_if.ca_row_id), 64'(row));
    chk({tag, "_buf"},   64'(bus_if.ca_buf_addr), 64'(buf_a));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus_if.ca_valid), 64'd0);
    chk({tag, "_ready"}, 64'(bus_if.req_ready), 64'd1);
    chk({tag, "_err"},   64'(bus_if.err), 64'd0);
  endtask

  task automatic expect_reset(input string tag);
    expect_idle(tag);
    chk({tag, "_word"}, 64'(bus_if.ca_word), 64'd0);
    chk({tag, "_len"},  64'(bus_if.ca_len), 64'd0);
    chk({tag, "_last"}, 64'(bus_if.ca_last), 64'd0);
    chk({tag, "_ids"},  64'({bus_if.ca_page_id, bus_if.ca_row_id, bus_if.ca_buf_addr}), 64'd0);
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_len   = '0;
    bus_if.req_read  = 1'b0;
    bus_if.req_reg   = 1'b0;
    bus_if.ca_ready  = 1'b1;
`ifdef HYPERRAM_CA_GEN_WRAP_EN
    bus_if.req_wrap  = 1'b0;
`endif
    #12;
    expect_reset("reset");
    rst_n = 1'b1;
    tick();

    // Single-page read
    send(32'h40, 10'd16, 1'b1, 1'b0, 1'b0);
    expect_ca("rd40", 48'hA000_0004_0000, 10'd16, 1'b1, 5'd2, 14'd0, 5'd0);
    chk("rd40_busy", 64'(bus_if.req_ready), 64'd0);
    tick();
    expect_idle("rd40_done");

    // Write crossing a page boundary, back-to-back CAs
    send(32'h3C, 10'd6, 1'b0, 1'b0, 1'b0);
    expect_ca("wr3c_a", 48'h2000_0003_0006, 10'd2, 1'b0, 5'd1, 14'd0, 5'd28);
    tick();
    expect_ca("wr3c_b", 48'h2000_0004_0000, 10'd4, 1'b1, 5'd2, 14'd0, 5'd0);
    tick();
    expect_idle("wr3c_done");

    // Back-pressure holds the first CA stable
    bus_if.ca_ready = 1'b0;
    send(32'h100, 10'd20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_ca("stall", 48'hA000_0010_0000, 10'd16, 1'b0, 5'd8, 14'd0, 5'd0);
      chk("stall_req_ready", 64'(bus_if.req_ready), 64'd0);
      tick();
    end
    bus_if.ca_ready = 1'b1;
    expect_ca("rd100_a", 48'hA000_0010_0000, 10'd16, 1'b0, 5'd8, 14'd0, 5'd0);
    tick();
    expect_ca("rd100_b", 48'hA000_0012_0000, 10'd4, 1'b1, 5'd9, 14'd0, 5'd0);
    tick();
    expect_idle("rd100_done");

    // Zero length is rejected with a single err pulse
    send(32'h80, 10'd0, 1'b1, 1'b0, 1'b0);
    chk("err_pulse", 64'(bus_if.err), 64'd1);
    chk("err_no_ca", 64'(bus_if.ca_valid), 64'd0);
    chk("err_busy", 64'(bus_if.req_ready), 64'd0);
    tick();
    expect_idle("err_done");

    // Asynchronous reset in the middle of a 3-chunk request
    send(32'h3C, 10'd20, 1'b0, 1'b0, 1'b0);
    expect_ca("rst_a", 48'h2000_0003_0006, 10'd2, 1'b0, 5'd1, 14'd0, 5'd28);
    tick();
    expect_ca("rst_b", 48'h2000_0004_0000, 10'd16, 1'b0, 5'd2, 14'd0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    expect_reset("rst_async");
    #1 rst_n = 1'b1;
    tick();
    expect_reset("rst_after");
    send(32'h200, 10'd4, 1'b1, 1'b0, 1'b0);
    expect_ca("post_rst", 48'hA000_0020_0000, 10'd4, 1'b1, 5'd16, 14'd0, 5'd0);
    tick();
    expect_idle("post_rst_done");

    // Register space: one CA, length forced to 1, address bit 0 ignored
    send(32'h2, 10'd5, 1'b0, 1'b1, 1'b0);
    expect_ca("regwr", 48'h6000_0000_0001, 10'd1, 1'b1, 5'd0, 14'd0, 5'd2);
    tick();
    expect_idle("regwr_done");
    send(32'h3, 10'd1, 1'b1, 1'b1, 1'b0);
    expect_ca("regrd", 48'hE000_0000_0001, 10'd1, 1'b1, 5'd0, 14'd0, 5'd2);
    tick();
    expect_idle("regrd_done");

    // Address wrap modulo 2^32 across the top page
    send(32'hFFFF_FFF0, 10'd16, 1'b1, 1'b0, 1'b0);
    expect_ca("top_a", 48'hAFFF_FFFF_0000, 10'd8, 1'b0, 5'd31, 14'h3FFF, 5'd16);
    tick();
    expect_ca("top_b", 48'hA000_0000_0000, 10'd8, 1'b1, 5'd0, 14'd0, 5'd0);
    tick();
    expect_idle("top_done");

`ifdef HYPERRAM_CA_GEN_WRAP_EN
    send(32'h40, 10'd16, 1'b1, 1'b0, 1'b1);
    expect_ca("wrap", 48'h8000_0004_0000, 10'd16, 1'b1, 5'd2, 14'd0, 5'd0);
    tick();
    expect_idle("wrap_done");
    send(32'h40, 10'd8, 1'b1, 1'b0, 1'b1);
    chk("wrap_badlen_err", 64'(bus_if.err), 64'd1);
    chk("wrap_badlen_no_ca", 64'(bus_if.ca_valid), 64'd0);
    tick();
    expect_idle("wrap_badlen_done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
